// File: rtl/la_fetch_npc_pkg.sv
// Shared definitions for the miniLA fetch / next-PC block.
//   - NPC_* : 2-bit next-PC select codes driven by the core on npc_sel
//   - fetch_state_e : fetch sequencer state encodings
//   - RESET_PC_DEFAULT : default first fetch address after reset
package la_fetch_npc_pkg;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_COND   = 2'b01;
  localparam logic [1:0] NPC_UNCOND = 2'b10;
  localparam logic [1:0] NPC_JIRL   = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;

  // ST_ERR is only reachable when NPC_ALIGN_CHECK_EN is defined.
  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_ERR   = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/la_npc_sel.sv
// Combinational next-PC selector.
// Ports:
//   pc4         in  : sequential successor of the current pc
//   npc_sel     in  : NPC_SEQ / NPC_COND / NPC_UNCOND / NPC_JIRL
//   alu_f       in  : ALU branch flag, only meaningful for NPC_COND
//   br_target   in  : pc-relative branch target
//   jirl_target in  : register-indirect jump target
//   npc         out : selected next pc (unaligned values passed through)
module la_npc_sel
  import la_fetch_npc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc4,
  input  logic [1:0]        npc_sel,
  input  logic              alu_f,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] jirl_target,
  output logic [ADDR_W-1:0] npc
);

  // Pick the successor address from the branch kind reported by the core.
  always_comb begin
    npc = pc4;
    case (npc_sel)
      NPC_SEQ:    npc = pc4;
      NPC_COND:   npc = alu_f ? br_target : pc4;
      NPC_UNCOND: npc = br_target;
      NPC_JIRL:   npc = jirl_target;
      default:    npc = pc4;
    endcase
  end

endmodule

// File: rtl/la_fetch_npc.sv
// PC register, next-PC update and instruction-fetch sequencer for miniLA.
// Sequence per instruction: REQ (hold request until gnt) -> WAIT (until
// rvalid) -> ISSUE (hold instruction until inst_ready) -> REQ.
// Optional macro NPC_ALIGN_CHECK_EN: adds the adef output; a misaligned next
// pc is loaded as-is and the sequencer parks in ST_ERR until reset. Without
// the macro the low two bits of the next pc are cleared instead.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   imem_req/imem_addr    : fetch request and address (address = pc)
//   imem_gnt              : memory accepted the request
//   imem_rvalid/rdata     : returned instruction word
//   inst_valid/inst/pc/pc4: instruction presented to execute
//   inst_ready            : execute handshake; npc_sel/alu_f/targets valid
//   npc_sel, alu_f        : branch kind and ALU flag
//   br_target/jirl_target : jump targets from the core
//   adef                  : alignment fault (macro builds only)
//   retire_cnt            : completed execute handshakes, wraps at 2^32
module la_fetch_npc
  import la_fetch_npc_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc4,
  input  logic              inst_ready,
  input  logic [1:0]        npc_sel,
  input  logic              alu_f,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] jirl_target,
`ifdef NPC_ALIGN_CHECK_EN
  output logic              adef,
`endif
  output logic [31:0]       retire_cnt
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] npc;
  logic [ADDR_W-1:0] pc_load;
  logic [31:0]       inst_q;
  logic [31:0]       retire_q;
  logic              handshake;
  logic              inst_load;

  assign handshake = (state_q == ST_ISSUE) && inst_ready;
  assign inst_load = (state_q == ST_WAIT) && imem_rvalid;
  assign pc4       = pc_q + ADDR_W'(4);

  la_npc_sel #(.ADDR_W(ADDR_W)) u_npc_sel (
    .pc4         (pc4),
    .npc_sel     (npc_sel),
    .alu_f       (alu_f),
    .br_target   (br_target),
    .jirl_target (jirl_target),
    .npc         (npc)
  );

`ifdef NPC_ALIGN_CHECK_EN
  logic fault;
  // The faulting address is kept so software can see where it went wrong.
  assign pc_load = npc;
  assign fault   = |npc[1:0];
  assign adef    = (state_q == ST_ERR);
`else
  assign pc_load = npc & ~ADDR_W'(3);
`endif

  // Next-state logic of the fetch sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_REQ;
      ST_REQ:   if (imem_gnt)    state_d = ST_WAIT;
      ST_WAIT:  if (imem_rvalid) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (inst_ready) begin
`ifdef NPC_ALIGN_CHECK_EN
          state_d = fault ? ST_ERR : ST_REQ;
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_ERR:   state_d = ST_ERR;
      default:  state_d = ST_BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // PC, latched instruction and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      inst_q   <= 32'd0;
      retire_q <= 32'd0;
    end else begin
      if (inst_load) inst_q <= imem_rdata;
      if (handshake) begin
        pc_q     <= pc_load;
        retire_q <= retire_q + 32'd1;
      end
    end
  end

  assign imem_req   = (state_q == ST_REQ);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == ST_ISSUE);
  assign inst       = inst_q;
  assign pc         = pc_q;
  assign retire_cnt = retire_q;

endmodule

// File: doc/la_fetch_npc.md
Name: la_fetch_npc

Overview:
- PC register, next-PC selection and instruction-fetch sequencer for the single-cycle miniLA core.
- Fetches one instruction through a req/gnt/rvalid instruction-memory interface and presents it to decode/execute.
- On the execute handshake, consumes the ALU branch flag f and the jump targets to pick the next PC.
- Downstream of the ALU's flag output; upstream of decode, register file and ALU.

Parameters:
RESET_PC, 32'h1C00_0000, first fetch address after reset
ADDR_W, 32, PC/address width (only 32 supported)

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  ADDR_W  fetch address, equals pc while imem_req=1
imem_gnt  input  1  memory accepted request this cycle
imem_rvalid  input  1  fetch data valid
imem_rdata  input  32  fetched instruction word
inst_valid  output  1  inst/pc/pc4 valid for execute
inst  output  32  latched instruction
pc  output  ADDR_W  address of inst
pc4  output  ADDR_W  pc+4 (BL/JIRL link value)
inst_ready  input  1  core has executed inst; npc_sel/alu_f/targets valid this cycle
npc_sel  input  2  00 SEQ, 01 COND, 10 UNCOND, 11 JIRL
alu_f  input  1  ALU branch flag f
br_target  input  ADDR_W  pc+offset computed by core
jirl_target  input  ADDR_W  ALU result C for JIRL
retire_cnt  output  32  count of completed execute handshakes

Behaviour:
- Clock clk; reset rst_n is asynchronous and active-low. While rst_n=0: state=BOOT, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, retire_cnt=0.
- States: BOOT, REQ, WAIT, ISSUE (plus ERR with the optional feature).
- BOOT: outputs idle; unconditionally to REQ next cycle.
- REQ: imem_req=1, imem_addr=pc, both held stable until imem_gnt=1; on gnt -> WAIT.
- WAIT: imem_req=0; on imem_rvalid=1, inst<=imem_rdata, -> ISSUE. rvalid in any other state is ignored. Memory asserts rvalid no earlier than the cycle after gnt.
- ISSUE: inst_valid=1; inst, pc and pc4 held stable. On inst_ready=1: pc<=npc, retire_cnt<=retire_cnt+1, -> REQ. inst_ready outside ISSUE is ignored.
- npc (sampled only in the ISSUE & inst_ready cycle):
  - SEQ: pc+4
  - COND: alu_f ? br_target : pc+4
  - UNCOND: br_target
  - JIRL: jirl_target
- pc4 = pc+4 combinational, modulo 2^32 (0xFFFF_FFFC wraps to 0). retire_cnt wraps at 2^32.
- Throughput with zero-wait memory (gnt in REQ, rvalid next cycle): 3 cycles per instruction (REQ, WAIT, ISSUE).
- inst_valid deasserts the cycle after the handshake.
- Reset mid-operation: immediate return to reset values. Instruction memory shares rst_n, so no in-flight response survives reset.

Optional Feature:
- Macro NPC_ALIGN_CHECK_EN.
- Defined:
  - Adds output port adef (1 bit, reset 0).
  - If npc[1:0]!=2'b00 at the handshake: pc<=npc (faulting address visible), retire_cnt still increments, state -> ERR.
  - ERR: adef=1, imem_req=0, inst_valid=0; exit only by reset.
- Undefined: no adef port; npc[1:0] forced to 2'b00 before loading pc.

Decomposition:
- Shared defines header (alongside the ALU op codes):
  - NPC_SEQ/NPC_COND/NPC_UNCOND/NPC_JIRL 2-bit codes
  - fetch state encodings
  - RESET_PC default constant
- One combinational sub-module, la_npc_sel: inputs pc4, npc_sel, alu_f, br_target, jirl_target; output npc. Keeps the FSM module purely sequential.

Test Plan:
- Reset release, memory grants immediately, rvalid next cycle with 0x0280_0421 -> imem_addr=0x1C00_0000; inst_valid on 3rd cycle after BOOT; inst=0x0280_0421; pc4=0x1C00_0004.
- SEQ handshake at pc=0x1C00_0000 -> next imem_addr=0x1C00_0004, retire_cnt=1.
- COND with alu_f=1, br_target=0x1C00_0040 -> pc=0x1C00_0040. Repeat with alu_f=0 -> pc=0x1C00_0044.
- gnt held low 4 cycles, then inst_ready low 5 cycles in ISSUE -> imem_addr/imem_req, inst and pc stable throughout; exactly one retire increment.
- JIRL with jirl_target=0x1C00_0102:
  - macro on -> adef=1 next cycle, pc=0x1C00_0102, imem_req stays 0.
  - macro off -> pc=0x1C00_0100.
- rst_n pulsed low during WAIT -> outputs return to reset values asynchronously; a stray rvalid afterwards is ignored; refetch from 0x1C00_0000.
